irs_nphase_write_controller: RTL and testbench
==============================================

Name: irs_nphase_write_controller

Overview:
Parametrised successor to the quad IRS write controller. It drives SSt/SSp/WRSTRB/WR for NUM_DAUGHTERS digitizers, with the sample array split into NUM_PHASES segments instead of fixed low/high halves. It fetches blocks from the block manager through a req/valid handshake and reports missed fetches. Everything runs in a single clock domain; SSp phase offset is applied downstream in the IOB.

Parameters:
NUM_DAUGHTERS, 4, number of IRS daughters driven.
BLOCK_BITS, 9, block address width. WR bus width is BLOCK_BITS+1; the MSB is write-enable.
NUM_PHASES, 2, segments per SSt period. Must be even and ≥2.
PHASE_CYCLES, 2, clk_i cycles per phase. Must be ≥2.
STRB_CYCLES, 1, WRSTRB-high cycles at the end of each phase. Range 1..PHASE_CYCLES-1.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
sync_i  in  1  alignment; RUN begins on the first cycle sync_i is sampled low
enable_i  in  1  write enable; 0 forces WR MSB=0 and suppresses requests and acks
mask_i  in  NUM_DAUGHTERS  per-daughter output enable; 0 holds that daughter's outputs at 0
blk_i  in  NUM_DAUGHTERS*BLOCK_BITS  packed block per daughter, daughter 0 in the LSBs
blk_valid_i  in  1  blk_i valid; sampled only while blk_req_o=1
blk_req_o  out  1  block request, one cycle per phase
req_phase_o  out  clog2(NUM_PHASES)  phase index the requested block is for
wr_ack_o  out  1  one-cycle pulse: the acked block has been written
ack_phase_o  out  clog2(NUM_PHASES)  phase index of the acked block
missed_o  out  1  one-cycle pulse: a request went unserviced
missed_cnt_o  out  16  saturating count of missed requests
ssp_o  out  NUM_DAUGHTERS  start strobe
sst_o  out  NUM_DAUGHTERS  stop strobe
wrstrb_o  out  NUM_DAUGHTERS  write strobe
wr_o  out  NUM_DAUGHTERS*(BLOCK_BITS+1)  packed WR bus per daughter
phase_o  out  clog2(NUM_PHASES)  current phase (debug)
state_o  out  2  FSM state (debug)

Behaviour:
- Reset: all outputs are 0 and missed_cnt=0. The FSM goes to ALIGN with phase=0, cyc=0 and primed=0.
- FSM states:
  - ALIGN(0): while sync_i=1, counters are held. On sync_i=0, go to RUN with phase=0, cyc=0.
  - RUN(1): runs continuously until reset.
  - State 2 and state 3 are unused; either one returns to ALIGN.
- Counters in RUN: cyc increments from 0 to PHASE_CYCLES-1, then wraps to 0 and increments phase. phase wraps from NUM_PHASES-1 to 0.
- primed is set at the first phase wrap to 0. It is not cleared until reset.
- All strobe outputs are registered, so the values below appear one cycle after the counter condition.
  - sst_o = (phase ≥ NUM_PHASES/2), i.e. a square wave whose period is NUM_PHASES*PHASE_CYCLES.
  - ssp_o = 1 for exactly one cycle, at phase=0, cyc=0.
  - wrstrb_o = (cyc ≥ PHASE_CYCLES-STRB_CYCLES).
- Request:
  - blk_req_o = RUN & enable_i & (cyc == PHASE_CYCLES-1).
  - req_phase_o = (phase+1) mod NUM_PHASES, i.e. the next phase.
- Latch, on the cycle after the request slot (start of next phase):
  - Request serviced (blk_valid_i=1): latch blk_i into each wr_o[d][BLOCK_BITS-1:0] and set WR MSB=1.
  - Request unserviced (blk_valid_i=0): keep the old address, set WR MSB=0, pulse missed_o, and increment missed_cnt, saturating at 0xFFFF.
  - enable_i=0 at the request slot: WR MSB=0 and no miss is counted.
- wr_o is stable for the whole phase; it changes only at cyc=0.
- Ack:
  - wr_ack_o pulses on the cycle after the last wrstrb-high cycle of the phase, with ack_phase_o set to that phase.
  - Issued only if that phase latched a valid block (MSB=1) and primed=1. Acks during the first SSt revolution are suppressed.
- Mask: when mask_i[d]=0, ssp/sst/wrstrb/wr for daughter d read 0. Internal sequencing is unaffected.
- Reset mid-RUN: outputs clear immediately (asynchronous). After release, operation requires re-alignment via sync_i.
- blk_valid_i outside the request slot is ignored.

Test Plan:
1. Defaults, sync_i low at release. Expect: sst_o period 4 cycles, 2 high / 2 low; ssp_o one pulse per 4 cycles; wrstrb_o high on every 2nd cycle.
2. Defaults, enable_i=1, valid always, blk_i daughter0=0x0A5. Expect: wr_o[0]=0x2A5 from the next phase start; no wr_ack_o during the first revolution; one ack per phase thereafter with ack_phase_o alternating 0,1.
3. Drop blk_valid_i for one request slot. Expect: missed_o one pulse, missed_cnt_o=1, WR MSB=0 for that phase, no ack for that phase, address unchanged.
4. Force missed_cnt to 0xFFFF, then miss again. Expect: missed_cnt_o stays 0xFFFF and missed_o still pulses.
5. NUM_PHASES=4, PHASE_CYCLES=4, STRB_CYCLES=2. Expect: sst_o 8 high / 8 low; wrstrb_o high for cycles 2-3 of each phase (plus register delay); req_phase_o sequence 1,2,3,0.
6. Hold sync_i=1 for 10 cycles, assert rst_i mid-phase, and set mask_i=4'b1011. Expect: outputs 0 during ALIGN; outputs 0 immediately on reset; daughter 2 outputs always 0.

Source files
------------

// File: rtl/irs_nphase_write_controller.sv
// N-phase IRS write controller: generates SSt/SSp/WRSTRB/WR for NUM_DAUGHTERS digitizers,
// fetching one block per phase from the block manager and counting missed fetches.
module irs_nphase_write_controller #(
  parameter int unsigned NUM_DAUGHTERS = 4,
  parameter int unsigned BLOCK_BITS    = 9,
  parameter int unsigned NUM_PHASES    = 2,
  parameter int unsigned PHASE_CYCLES  = 2,
  parameter int unsigned STRB_CYCLES   = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   sync_i,
  input  logic                                   enable_i,
  input  logic [NUM_DAUGHTERS-1:0]               mask_i,
  input  logic [NUM_DAUGHTERS*BLOCK_BITS-1:0]    blk_i,
  input  logic                                   blk_valid_i,
  output logic                                   blk_req_o,
  output logic [$clog2(NUM_PHASES)-1:0]          req_phase_o,
  output logic                                   wr_ack_o,
  output logic [$clog2(NUM_PHASES)-1:0]          ack_phase_o,
  output logic                                   missed_o,
  output logic [15:0]                            missed_cnt_o,
  output logic [NUM_DAUGHTERS-1:0]               ssp_o,
  output logic [NUM_DAUGHTERS-1:0]               sst_o,
  output logic [NUM_DAUGHTERS-1:0]               wrstrb_o,
  output logic [NUM_DAUGHTERS*(BLOCK_BITS+1)-1:0] wr_o,
  output logic [$clog2(NUM_PHASES)-1:0]          phase_o,
  output logic [1:0]                             state_o
);

  localparam int unsigned PW = $clog2(NUM_PHASES);
  localparam int unsigned CW = $clog2(PHASE_CYCLES);
  localparam int unsigned WW = BLOCK_BITS + 1;

  typedef enum logic [1:0] {
    ALIGN   = 2'd0,
    RUN     = 2'd1,
    UNUSED2 = 2'd2,
    UNUSED3 = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]         phase_q;
  logic [CW-1:0]         cyc_q;
  logic                  primed_q;
  logic                  in_run, last_cyc, last_phase;
  logic                  ssp_q, sst_q, wrstrb_q;
  logic                  msb_q, ack_pend_q, wr_ack_q, missed_q;
  logic [PW-1:0]         ack_ph_q, ack_phase_q;
  logic [15:0]           missed_cnt_q;
  logic [BLOCK_BITS-1:0] addr_q [NUM_DAUGHTERS];

  assign in_run     = (state_q == RUN);
  assign last_cyc   = (cyc_q == CW'(PHASE_CYCLES - 1));
  assign last_phase = (phase_q == PW'(NUM_PHASES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ALIGN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIGN:   if (!sync_i) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = ALIGN;
    endcase
  end

  always_comb begin
    blk_req_o = in_run & enable_i & last_cyc;
    state_o   = state_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q  <= '0;
      cyc_q    <= '0;
      primed_q <= 1'b0;
    end else if (!in_run) begin
      phase_q <= '0;
      cyc_q   <= '0;
    end else if (last_cyc) begin
      cyc_q   <= '0;
      phase_q <= last_phase ? '0 : phase_q + PW'(1);
      if (last_phase) primed_q <= 1'b1;
    end else begin
      cyc_q <= cyc_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ssp_q    <= 1'b0;
      sst_q    <= 1'b0;
      wrstrb_q <= 1'b0;
    end else begin
      ssp_q    <= in_run && (phase_q == '0) && (cyc_q == '0);
      sst_q    <= in_run && (phase_q >= PW'(NUM_PHASES / 2));
      wrstrb_q <= in_run && (cyc_q >= CW'(PHASE_CYCLES - STRB_CYCLES));
    end
  end

  // The ending phase's MSB is stashed at the request slot because the new
  // block overwrites it at cyc 0, one cycle before that phase's ack is due.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msb_q        <= 1'b0;
      ack_pend_q   <= 1'b0;
      ack_ph_q     <= '0;
      ack_phase_q  <= '0;
      wr_ack_q     <= 1'b0;
      missed_q     <= 1'b0;
      missed_cnt_q <= '0;
      for (int unsigned d = 0; d < NUM_DAUGHTERS; d++) addr_q[d] <= '0;
    end else begin
      missed_q <= 1'b0;
      wr_ack_q <= 1'b0;
      if (in_run && last_cyc) begin
        ack_pend_q <= msb_q & primed_q;
        ack_ph_q   <= phase_q;
        if (enable_i && blk_valid_i) begin
          msb_q <= 1'b1;
          for (int unsigned d = 0; d < NUM_DAUGHTERS; d++)
            addr_q[d] <= blk_i[d*BLOCK_BITS +: BLOCK_BITS];
        end else begin
          msb_q <= 1'b0;
          if (enable_i) begin
            missed_q <= 1'b1;
            if (missed_cnt_q != '1) missed_cnt_q <= missed_cnt_q + 16'd1;
          end
        end
      end
      if (in_run && (cyc_q == '0)) begin
        wr_ack_q <= ack_pend_q;
        if (ack_pend_q) ack_phase_q <= ack_ph_q;
      end
    end
  end

  always_comb begin
    ssp_o    = {NUM_DAUGHTERS{ssp_q}} & mask_i;
    sst_o    = {NUM_DAUGHTERS{sst_q}} & mask_i;
    wrstrb_o = {NUM_DAUGHTERS{wrstrb_q}} & mask_i;
    wr_o     = '0;
    for (int unsigned d = 0; d < NUM_DAUGHTERS; d++)
      if (mask_i[d]) wr_o[d*WW +: WW] = {msb_q, addr_q[d]};
  end

  assign req_phase_o  = last_phase ? '0 : phase_q + PW'(1);
  assign wr_ack_o     = wr_ack_q;
  assign ack_phase_o  = ack_phase_q;
  assign missed_o     = missed_q;
  assign missed_cnt_o = missed_cnt_q;
  assign phase_o      = phase_q;

endmodule

// File: tb/tb_irs_nphase_write_controller.sv
// Scoreboard bench: the stimulus process models each cycle arithmetically from elapsed RUN
// time and queues expected outputs; a negedge monitor pops and compares.
module tb_irs_nphase_write_controller;

  localparam int unsigned ND = 4;
  localparam int unsigned BB = 9;
  localparam int unsigned NP = 4;
  localparam int unsigned PC = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned WW = BB + 1;

  logic              clk_i = 1'b0;
  logic              rst_i, sync_i, enable_i, blk_valid_i;
  logic [ND-1:0]     mask_i;
  logic [ND*BB-1:0]  blk_i;
  logic              blk_req_o, wr_ack_o, missed_o;
  logic [1:0]        req_phase_o, ack_phase_o, phase_o, state_o;
  logic [15:0]       missed_cnt_o;
  logic [ND-1:0]     ssp_o, sst_o, wrstrb_o;
  logic [ND*WW-1:0]  wr_o;

  irs_nphase_write_controller #(
    .NUM_DAUGHTERS(ND), .BLOCK_BITS(BB), .NUM_PHASES(NP),
    .PHASE_CYCLES(PC), .STRB_CYCLES(SC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sync_i(sync_i), .enable_i(enable_i),
    .mask_i(mask_i), .blk_i(blk_i), .blk_valid_i(blk_valid_i),
    .blk_req_o(blk_req_o), .req_phase_o(req_phase_o), .wr_ack_o(wr_ack_o),
    .ack_phase_o(ack_phase_o), .missed_o(missed_o), .missed_cnt_o(missed_cnt_o),
    .ssp_o(ssp_o), .sst_o(sst_o), .wrstrb_o(wrstrb_o), .wr_o(wr_o),
    .phase_o(phase_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [ND-1:0]    ssp, sst, wrstrb;
    logic             req;
    logic [1:0]       rph;
    logic             ack;
    logic [1:0]       aph;
    logic             miss;
    logic [15:0]      cnt;
    logic [ND*WW-1:0] wr;
    logic [1:0]       st, ph;
  } exp_t;

  typedef struct { int at; int ph; } ack_t;

  exp_t exp_q[$];
  ack_t ack_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // Reference model state: time since RUN began, the latched block and the miss count
  bit           run = 0;
  int           t = 0;
  logic [ND*BB-1:0] m_blk = '0;
  bit           m_msb = 0;
  logic [15:0]  m_cnt = '0;
  bit           p_rst = 1, p_sync = 1, p_en = 0, p_valid = 0;
  logic [ND*BB-1:0] p_blk = '0;

  task automatic tick(input bit rs, input bit s, input bit en, input bit v,
                      input logic [ND*BB-1:0] b, input logic [ND-1:0] m, input bit do_force);
    exp_t e;
    int   tp;
    bit   miss_now;
    @(posedge clk_i);
    miss_now = 0;
    if (!p_rst) begin
      if (!run) begin
        if (!p_sync) begin run = 1; t = 0; end
      end else begin
        tp = t;
        t  = t + 1;
        if (tp % PC == PC - 1) begin
          // the phase now ending is acknowledged if it held a block and lies past revolution one
          if (m_msb && tp >= int'(NP * PC)) ack_q.push_back('{at: tp + 2, ph: (tp / PC) % NP});
          miss_now = p_en && !p_valid;
          if (p_en && p_valid) begin m_msb = 1; m_blk = p_blk; end
          else m_msb = 0;
          if (miss_now && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
    end
    #2;
    rst_i = rs; sync_i = s; enable_i = en; blk_valid_i = v; blk_i = b; mask_i = m;
    if (rs) begin
      run = 0; t = 0; m_msb = 0; m_blk = '0; m_cnt = '0; miss_now = 0;
      ack_q.delete();
      if (!p_rst) begin
        #1;
        chk("rst_async_sst", 64'(sst_o), 64'(0));
        chk("rst_async_wrstrb", 64'(wrstrb_o), 64'(0));
        chk("rst_async_wr", 64'(wr_o), 64'(0));
        chk("rst_async_cnt", 64'(missed_cnt_o), 64'(0));
      end
    end
    if (do_force) begin
      force dut.missed_cnt_q = 16'hFFFD;
      #1 release dut.missed_cnt_q;
      m_cnt = 16'hFFFD;
    end
    e.ssp = '0; e.sst = '0; e.wrstrb = '0; e.req = 0; e.rph = '0; e.ack = 0; e.aph = '0;
    e.miss = miss_now; e.cnt = m_cnt; e.st = run ? 2'd1 : 2'd0; e.ph = '0;
    if (run) begin
      e.ph  = 2'((t / PC) % NP);
      e.req = en && (t % PC == PC - 1);
      e.rph = 2'(((t / PC) + 1) % NP);
      if (t >= 1) begin
        e.ssp    = {ND{((t - 1) % (NP * PC)) == 0}} & m;
        e.sst    = {ND{(((t - 1) / PC) % NP) >= NP / 2}} & m;
        e.wrstrb = {ND{((t - 1) % PC) >= PC - SC}} & m;
      end
      if (ack_q.size() > 0 && ack_q[0].at == t) begin
        e.ack = 1; e.aph = 2'(ack_q[0].ph);
        void'(ack_q.pop_front());
      end
    end
    e.wr = '0;
    for (int d = 0; d < ND; d++)
      if (m[d]) e.wr[d*WW +: WW] = {m_msb, m_blk[d*BB +: BB]};
    exp_q.push_back(e);
    p_rst = rs; p_sync = s; p_en = en; p_valid = v; p_blk = b;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ssp", 64'(ssp_o), 64'(e.ssp));
        chk("sst", 64'(sst_o), 64'(e.sst));
        chk("wrstrb", 64'(wrstrb_o), 64'(e.wrstrb));
        chk("blk_req", 64'(blk_req_o), 64'(e.req));
        if (e.req) chk("req_phase", 64'(req_phase_o), 64'(e.rph));
        chk("wr_ack", 64'(wr_ack_o), 64'(e.ack));
        if (e.ack) chk("ack_phase", 64'(ack_phase_o), 64'(e.aph));
        chk("missed", 64'(missed_o), 64'(e.miss));
        chk("missed_cnt", 64'(missed_cnt_o), 64'(e.cnt));
        chk("wr", 64'(wr_o), 64'(e.wr));
        chk("state", 64'(state_o), 64'(e.st));
        chk("phase", 64'(phase_o), 64'(e.ph));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [ND*BB-1:0] blk_a, rb;
    logic [ND-1:0]    msk;
    rst_i = 1; sync_i = 1; enable_i = 0; blk_valid_i = 0; blk_i = '0; mask_i = '1;
    #1;
    chk("reset_sst", 64'(sst_o), 64'(0));
    chk("reset_ssp", 64'(ssp_o), 64'(0));
    chk("reset_wr", 64'(wr_o), 64'(0));
    chk("reset_cnt", 64'(missed_cnt_o), 64'(0));
    chk("reset_state", 64'(state_o), 64'(0));

    blk_a = 36'({$urandom, $urandom});
    blk_a[BB-1:0] = 9'h0A5;
    repeat (2)  tick(1, 1, 0, 0, '0, 4'hF, 0);
    repeat (10) tick(0, 1, 1, 1, blk_a, 4'hF, 0);
    repeat (56) tick(0, 0, 1, 1, blk_a, 4'hF, 0);

    msk = 4'hF;
    for (int i = 0; i < 200; i++) begin
      rb = 36'({$urandom, $urandom});
      if (i % 25 == 24) msk = 4'($urandom);
      tick(0, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, rb, msk, 0);
    end

    tick(0, 0, 1, 0, '0, 4'hF, 1);
    repeat (20) tick(0, 0, 1, 0, 36'({$urandom, $urandom}), 4'hF, 0);
    repeat (8)  tick(0, 0, 1, 1, 36'({$urandom, $urandom}), 4'hF, 0);

    repeat (6) tick(0, 0, 1, 1, 36'({$urandom, $urandom}), 4'b1011, 0);
    repeat (3) tick(1, 1, 1, 1, 36'({$urandom, $urandom}), 4'b1011, 0);
    repeat (10) tick(0, 1, 1, 1, 36'({$urandom, $urandom}), 4'b1011, 0);
    for (int i = 0; i < 80; i++)
      tick(0, 0, 1, $urandom_range(0, 4) != 0, 36'({$urandom, $urandom}), 4'b1011, 0);

    @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
